// File: rtl/im_loader_if.sv
// rtl/im_loader_if.sv - host byte stream and IM write port bundle for the program loader
interface im_loader_if #(
   parameter int IMW = 4,
   parameter int IW  = 32
);
   logic           in_valid;
   logic [7:0]     in_data;
   logic           in_ready;
   logic           im_we;
   logic [IMW-1:0] im_addr;
   logic [IW-1:0]  im_wdata;

   // master: the loader (sinks the byte stream, drives the IM write port)
   modport master (
      input  in_valid, in_data,
      output in_ready, im_we, im_addr, im_wdata
   );

   // slave: host byte source plus IM write receiver
   modport slave (
      output in_valid, in_data,
      input  in_ready, im_we, im_addr, im_wdata
   );
endinterface

// File: rtl/im_loader.sv
// rtl/im_loader.sv - packs a header-prefixed byte stream into IM words, then releases the core
module im_loader #(
   parameter int IMW = 4,
   parameter int IW  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_req,
   im_loader_if.master bus,
   output logic        core_start,
   output logic        busy,
   output logic        done,
   output logic        err
);
   localparam int BPW = IW / 8;
   localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [8:0]    LIMIT = 9'(1 << IMW);
   localparam logic [BW-1:0] BLAST = BW'(BPW - 1);
   localparam logic [BW-1:0] BONE  = BW'(1);
   localparam logic [IMW:0]  WONE  = (IMW + 1)'(1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_BYTES, S_WRITE, S_DONE, S_ERR} state_t;

   state_t         state, state_n;
   logic [8:0]     cnt, cnt_n;
   logic [BW-1:0]  byte_idx, byte_n;
   logic [IMW:0]   word_idx, word_idx_n;
   logic [IW-1:0]  word, word_n;
   logic [IMW-1:0] addr_q, addr_n;
   logic [IW-1:0]  wdata_q, wdata_n;
   logic           ready_q, ready_n;
   logic           we_q, we_n;
   logic           start_n, busy_n, done_n, err_n;
   logic           xfer;

   assign bus.in_ready = ready_q;
   assign bus.im_we    = we_q;
   assign bus.im_addr  = addr_q;
   assign bus.im_wdata = wdata_q;
   assign xfer         = bus.in_valid & ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         byte_idx   <= '0;
         word_idx   <= '0;
         word       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         core_start <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         byte_idx   <= byte_n;
         word_idx   <= word_idx_n;
         word       <= word_n;
         addr_q     <= addr_n;
         wdata_q    <= wdata_n;
         ready_q    <= ready_n;
         we_q       <= we_n;
         core_start <= start_n;
         busy       <= busy_n;
         done       <= done_n;
         err        <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      byte_n     = byte_idx;
      word_idx_n = word_idx;
      word_n     = word;
      addr_n     = addr_q;
      wdata_n    = wdata_q;

      case (state)
         S_IDLE: if (load_req) state_n = S_HDR;
         S_HDR: begin
            if (xfer) begin
               cnt_n = {1'b0, bus.in_data};
               if (bus.in_data == 8'd0) begin
                  state_n = S_DONE;
               end else if ({1'b0, bus.in_data} > LIMIT) begin
                  state_n = S_ERR;
               end else begin
                  state_n    = S_BYTES;
                  byte_n     = '0;
                  word_idx_n = '0;
               end
            end
         end
         S_BYTES: begin
            if (xfer) begin
               word_n[8*byte_idx +: 8] = bus.in_data;
               if (byte_idx == BLAST) begin
                  // write port regs only change on entry to WRITE so they hold otherwise
                  state_n = S_WRITE;
                  addr_n  = word_idx[IMW-1:0];
                  wdata_n = word_n;
               end else begin
                  byte_n = byte_idx + BONE;
               end
            end
         end
         S_WRITE: begin
            if (9'(word_idx) + 9'd1 == cnt) begin
               state_n = S_DONE;
            end else begin
               state_n    = S_BYTES;
               word_idx_n = word_idx + WONE;
               byte_n     = '0;
            end
         end
         S_DONE, S_ERR: if (load_req) state_n = S_HDR;
         default: state_n = S_IDLE;
      endcase

      ready_n = (state_n == S_HDR) || (state_n == S_BYTES);
      we_n    = (state_n == S_WRITE);
      start_n = (state_n == S_DONE) && (state != S_DONE);
      busy_n  = (state_n == S_HDR) || (state_n == S_BYTES) || (state_n == S_WRITE);
      done_n  = (state_n == S_DONE);
      err_n   = (state_n == S_ERR);
   end
endmodule

// File: tb/tb_im_loader.sv
// tb/tb_im_loader.sv - directed self-checking bench for im_loader
module tb_im_loader;
   localparam int IMW = 4;
   localparam int IW  = 32;

   logic clk = 1'b0;
   logic rst;
   logic load_req;
   logic core_start, busy, done, err;

   im_loader_if #(.IMW(IMW), .IW(IW)) bus();

   im_loader #(.IMW(IMW), .IW(IW)) dut (
      .clk(clk), .rst(rst), .load_req(load_req), .bus(bus),
      .core_start(core_start), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int nw = 0;
   int nstart = 0;
   int base_w, base_s;
   logic [IMW-1:0] wr_addr [256];
   logic [IW-1:0]  wr_data [256];

   always @(negedge clk) begin
      if (bus.im_we === 1'b1 && nw < 256) begin
         wr_addr[nw] <= bus.im_addr;
         wr_data[nw] <= bus.im_wdata;
         nw <= nw + 1;
      end
      if (core_start === 1'b1) nstart <= nstart + 1;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) begin bus.in_valid = 1'b0; @(negedge clk); end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      total++;
      if (t >= 50) begin bad++; $display("FAIL byte_accept data=%02h in_ready=%b required=1", b, bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_stream(input logic [7:0] s[$], input int maxgap);
      foreach (s[i]) send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (done !== 1'b1 && err !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      total++;
      if (t >= 300) begin bad++; $display("FAIL wait_done timeout done=%b required=1", done); end
      repeat (2) @(negedge clk);
   endtask

   task automatic snap();
      @(negedge clk);
      base_w = nw;
      base_s = nstart;
   endtask

   task automatic test_reset();
      rst = 1'b1; load_req = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
      total++; if (bus.im_we !== 1'b0) begin bad++; $display("FAIL rst_im_we got=%b exp=0", bus.im_we); end
      total++; if (bus.im_addr !== 4'h0) begin bad++; $display("FAIL rst_im_addr got=%h exp=0", bus.im_addr); end
      total++; if (bus.im_wdata !== 32'h0) begin bad++; $display("FAIL rst_im_wdata got=%h exp=0", bus.im_wdata); end
      total++; if ({core_start, busy, done, err} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {core_start, busy, done, err}); end
   endtask

   task automatic run_two_words(input string tag, input int maxgap);
      snap();
      pulse_load();
      send_stream('{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, maxgap);
      wait_done();
      total++; if (nw - base_w !== 2) begin bad++; $display("FAIL %s_strobes got=%0d exp=2", tag, nw - base_w); end
      total++; if (wr_addr[base_w] !== 4'd0 || wr_data[base_w] !== 32'h12345678) begin bad++; $display("FAIL %s_word0 got=%h@%0d exp=12345678@0", tag, wr_data[base_w], wr_addr[base_w]); end
      total++; if (wr_addr[base_w+1] !== 4'd1 || wr_data[base_w+1] !== 32'hDEADBEEF) begin bad++; $display("FAIL %s_word1 got=%h@%0d exp=deadbeef@1", tag, wr_data[base_w+1], wr_addr[base_w+1]); end
      total++; if (nstart - base_s !== 1) begin bad++; $display("FAIL %s_core_start got=%0d exp=1", tag, nstart - base_s); end
      total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL %s_done got=%b/%b exp=1/0", tag, done, busy); end
   endtask

   task automatic test_basic();
      run_two_words("basic", 0);
   endtask

   task automatic test_gaps();
      run_two_words("gaps", 3);
   endtask

   task automatic test_empty();
      snap();
      pulse_load();
      send_byte(8'h00, 0);
      total++; if (core_start !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL empty_start got=%b/%b exp=1/1", core_start, done); end
      repeat (2) @(negedge clk);
      total++; if (core_start !== 1'b0) begin bad++; $display("FAIL empty_start_width got=%b exp=0", core_start); end
      total++; if (nw - base_w !== 0 || nstart - base_s !== 1) begin bad++; $display("FAIL empty_counts got=%0d/%0d exp=0/1", nw - base_w, nstart - base_s); end
   endtask

   task automatic test_err();
      snap();
      pulse_load();
      send_byte(8'h11, 0);
      total++; if (err !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL err_flags got=%b%b%b%b exp=1000", err, bus.in_ready, busy, done); end
      bus.in_valid = 1'b1; bus.in_data = 8'hAA;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (nw - base_w !== 0 || nstart - base_s !== 0 || err !== 1'b1) begin bad++; $display("FAIL err_quiet got=%0d/%0d/%b exp=0/0/1", nw - base_w, nstart - base_s, err); end
      pulse_load();
      total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL err_clear got=%b/%b exp=0/1", err, busy); end
      send_stream('{8'h01, 8'h44, 8'h33, 8'h22, 8'h11}, 0);
      wait_done();
      total++; if (nw - base_w !== 1 || wr_addr[base_w] !== 4'd0 || wr_data[base_w] !== 32'h11223344) begin bad++; $display("FAIL err_reload got=%0d %h@%0d exp=1 11223344@0", nw - base_w, wr_data[base_w], wr_addr[base_w]); end
      total++; if (err !== 1'b0 || done !== 1'b1 || nstart - base_s !== 1) begin bad++; $display("FAIL err_reload_flags got=%b/%b/%0d exp=0/1/1", err, done, nstart - base_s); end
   endtask

   task automatic test_reset_mid();
      snap();
      pulse_load();
      send_stream('{8'h02, 8'h78, 8'h56}, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.im_we !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b%b%b%b exp=0000", busy, bus.in_ready, bus.im_we, done); end
      repeat (5) @(negedge clk);
      total++; if (nw - base_w !== 0 || nstart - base_s !== 0) begin bad++; $display("FAIL midrst_quiet got=%0d/%0d exp=0/0", nw - base_w, nstart - base_s); end
      run_two_words("midrst_reload", 0);
   endtask

   task automatic test_full();
      logic [7:0] s[$];
      logic [IW-1:0] exp_w;
      s.push_back(8'h10);
      for (int i = 0; i < 64; i++) s.push_back(8'(i));
      snap();
      pulse_load();
      send_stream(s, 0);
      wait_done();
      total++; if (nw - base_w !== 16) begin bad++; $display("FAIL full_strobes got=%0d exp=16", nw - base_w); end
      for (int i = 0; i < 16; i++) begin
         exp_w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
         total++; if (wr_addr[base_w+i] !== 4'(i) || wr_data[base_w+i] !== exp_w) begin bad++; $display("FAIL full_word%0d got=%h@%0d exp=%h@%0d", i, wr_data[base_w+i], wr_addr[base_w+i], exp_w, i); end
      end
      total++; if (nstart - base_s !== 1 || done !== 1'b1) begin bad++; $display("FAIL full_start got=%0d/%b exp=1/1", nstart - base_s, done); end
      pulse_load();
      total++; if (done !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_restart got=%b%b%b exp=011", done, busy, bus.in_ready); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_empty();
      test_err();
      test_reset_mid();
      test_full();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
